// File: rtl/vm_change_dispenser.sv
// Change payout for the vending machine: greedy quarter/dime/nickel selection,
// one coin per valid/ack handshake, saturating refillable inventory.
// Optional ack watchdog enabled by defining VM_CHANGE_TIMEOUT_EN.
module vm_change_dispenser #(
  parameter int AMT_W    = 8,
  parameter int INV_W    = 4,
  parameter int INIT_CNT = 0,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
  output logic             change_ready,
  input  logic             refill_valid,
  input  logic [1:0]       refill_type,
  input  logic [INV_W-1:0] refill_cnt,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic             busy,
  output logic [INV_W-1:0] n_cnt,
  output logic [INV_W-1:0] d_cnt,
  output logic [INV_W-1:0] q_cnt,
  output logic             fault
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SELECT   = 2'd1;
  localparam logic [1:0] DISPENSE = 2'd2;

  localparam logic [1:0] COIN_N = 2'd1;
  localparam logic [1:0] COIN_D = 2'd2;
  localparam logic [1:0] COIN_Q = 2'd3;

  localparam logic [INV_W-1:0] INV_MAX  = '1;
  localparam logic [INV_W-1:0] INV_INIT = INV_W'(INIT_CNT);

  logic [1:0]       state;
  logic [AMT_W-1:0] remaining;
  logic [1:0]       pick;
  logic             ack_take;
  logic             to_fire;

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] t);
    case (t)
      COIN_Q:  return AMT_W'(25);
      COIN_D:  return AMT_W'(10);
      COIN_N:  return AMT_W'(5);
      default: return '0;
    endcase
  endfunction

  // Decrement-by-ack and refill can land on the same edge; clamp at the counter maximum.
  function automatic logic [INV_W-1:0] sat_update(input logic [INV_W-1:0] cnt,
                                                  input logic dec,
                                                  input logic add_en,
                                                  input logic [INV_W-1:0] add);
    logic [INV_W:0] sum;
    sum = {1'b0, cnt} - {{INV_W{1'b0}}, dec} + (add_en ? {1'b0, add} : {(INV_W+1){1'b0}});
    return (sum > {1'b0, INV_MAX}) ? INV_MAX : sum[INV_W-1:0];
  endfunction

  assign change_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign ack_take     = (state == DISPENSE) && coin_ack;

  // Greedy choice: largest coin that fits and is in stock.
  always_comb begin
    pick = 2'd0;
    if (remaining >= AMT_W'(25) && q_cnt != '0)      pick = COIN_Q;
    else if (remaining >= AMT_W'(10) && d_cnt != '0) pick = COIN_D;
    else if (remaining >= AMT_W'(5) && n_cnt != '0)  pick = COIN_N;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_cnt <= INV_INIT;
      d_cnt <= INV_INIT;
      q_cnt <= INV_INIT;
    end else begin
      n_cnt <= sat_update(n_cnt, ack_take && coin_type == COIN_N,
                          refill_valid && refill_type == COIN_N, refill_cnt);
      d_cnt <= sat_update(d_cnt, ack_take && coin_type == COIN_D,
                          refill_valid && refill_type == COIN_D, refill_cnt);
      q_cnt <= sat_update(q_cnt, ack_take && coin_type == COIN_Q,
                          refill_valid && refill_type == COIN_Q, refill_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      remaining  <= '0;
      coin_valid <= 1'b0;
      coin_type  <= 2'd0;
      done       <= 1'b0;
      shortfall  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (change_valid) begin
            remaining <= change_amt;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (pick != 2'd0) begin
            coin_valid <= 1'b1;
            coin_type  <= pick;
            state      <= DISPENSE;
          end else begin
            done      <= 1'b1;
            shortfall <= remaining;
            state     <= IDLE;
          end
        end
        DISPENSE: begin
          if (coin_ack) begin
            coin_valid <= 1'b0;
            remaining  <= remaining - coin_value(coin_type);
            state      <= SELECT;
          end else if (to_fire) begin
            // Abandoned coin stays counted as unpaid; inventory untouched.
            coin_valid <= 1'b0;
            done       <= 1'b1;
            shortfall  <= remaining;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VM_CHANGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  assign to_fire = (state == DISPENSE) && !coin_ack && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      if (state == SELECT)
        to_cnt <= '0;
      else if (state == DISPENSE && !coin_ack && !to_fire)
        to_cnt <= to_cnt + 1'b1;
      if (to_fire)
        fault <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign fault   = 1'b0;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end
`endif

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Bench for vm_change_dispenser: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a behavioural payout model.
module tb_vm_change_dispenser;
  localparam int AMT_W   = 8;
  localparam int INV_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int INV_MAX = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             change_valid = 1'b0;
  logic [AMT_W-1:0] change_amt = '0;
  logic             change_ready;
  logic             refill_valid = 1'b0;
  logic [1:0]       refill_type = 2'd0;
  logic [INV_W-1:0] refill_cnt = '0;
  logic             coin_valid;
  logic [1:0]       coin_type;
  logic             coin_ack;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic             busy;
  logic [INV_W-1:0] n_cnt, d_cnt, q_cnt;
  logic             fault;

  int tests = 0;
  int fails = 0;
  int ack_mode = 1;      // 0 random, 1 never, 2 immediate, 3 manual
  logic auto_ack = 1'b0;
  logic man_ack = 1'b0;

  always #5 clk = ~clk;

  assign coin_ack = (ack_mode == 3) ? man_ack : auto_ack;

  vm_change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .INIT_CNT(0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .change_valid(change_valid), .change_amt(change_amt), .change_ready(change_ready),
    .refill_valid(refill_valid), .refill_type(refill_type), .refill_cnt(refill_cnt),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ack(coin_ack),
    .done(done), .shortfall(shortfall), .busy(busy),
    .n_cnt(n_cnt), .d_cnt(d_cnt), .q_cnt(q_cnt), .fault(fault)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a payout is a busy window; each coin is decided one edge
  // after acceptance or after the previous ack, using the inventory before that edge.
  int m_inv [1:3];
  int m_rem, m_coin, m_short, m_wait, m_pick, m_dec, m_v;
  bit m_busy, m_think, m_done, m_fault;

  function automatic int value_of(input int t);
    return (t == 3) ? 25 : (t == 2) ? 10 : (t == 1) ? 5 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_think = 0; m_coin = 0; m_rem = 0; m_done = 0;
      m_short = 0; m_fault = 0; m_wait = 0;
      for (int t = 1; t <= 3; t++) m_inv[t] = 0;
    end else begin
      m_pick = 0;
      m_dec = 0;
      m_done = 0;
      if (!m_busy) begin
        if (change_valid) begin
          m_busy = 1; m_think = 1; m_rem = int'(change_amt);
        end
      end else if (m_think) begin
        m_think = 0;
        if (m_rem >= 25 && m_inv[3] > 0)      m_pick = 3;
        else if (m_rem >= 10 && m_inv[2] > 0) m_pick = 2;
        else if (m_rem >= 5 && m_inv[1] > 0)  m_pick = 1;
        if (m_pick != 0) begin
          m_coin = m_pick; m_wait = 0;
        end else begin
          m_done = 1; m_short = m_rem; m_busy = 0;
        end
      end else if (coin_ack) begin
        m_dec = m_coin; m_rem -= value_of(m_coin); m_coin = 0; m_think = 1;
      end
`ifdef VM_CHANGE_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_fault = 1; m_done = 1; m_short = m_rem; m_coin = 0; m_busy = 0;
        end
      end
`endif
      for (int t = 1; t <= 3; t++) begin
        m_v = m_inv[t] - ((m_dec == t) ? 1 : 0) +
              ((refill_valid && int'(refill_type) == t) ? int'(refill_cnt) : 0);
        m_inv[t] = (m_v > INV_MAX) ? INV_MAX : m_v;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("coin_valid", int'(coin_valid), int'(m_coin != 0));
      if (m_coin != 0) chk("coin_type", int'(coin_type), m_coin);
      chk("done", int'(done), int'(m_done));
      chk("shortfall", int'(shortfall), m_short);
      chk("busy", int'(busy), int'(m_busy));
      chk("change_ready", int'(change_ready), int'(!m_busy));
      chk("n_cnt", int'(n_cnt), m_inv[1]);
      chk("d_cnt", int'(d_cnt), m_inv[2]);
      chk("q_cnt", int'(q_cnt), m_inv[3]);
      chk("fault", int'(fault), int'(m_fault));
    end
  end

  always @(negedge clk) begin
    case (ack_mode)
      0:       auto_ack = ($urandom_range(0, 2) == 0);
      2:       auto_ack = (m_coin != 0);
      default: auto_ack = 1'b0;
    endcase
  end

  task automatic do_reset();
    change_valid = 0; refill_valid = 0; man_ack = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic refill(input int t, input int c);
    @(negedge clk);
    refill_valid = 1; refill_type = 2'(t); refill_cnt = INV_W'(c);
    @(negedge clk);
    refill_valid = 0;
  endtask

  // Offer an amount; return the number of edges until coin_valid or done shows.
  task automatic start(input int amt, output int lat);
    @(negedge clk);
    change_valid = 1; change_amt = AMT_W'(amt);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      change_valid = 0;
      if (coin_valid || done) begin
        lat = i;
        break;
      end
    end
    chk("start_response_seen", int'(lat != 0), 1);
  endtask

  task automatic expect_coin(input int t);
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (coin_valid) begin
        seen = 1;
        break;
      end
    end
    chk("coin_seen", seen, 1);
    chk("coin_order", int'(coin_type), t);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    chk("done_seen", int'(n != 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, n;

    do_reset();
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_shortfall", int'(shortfall), 0);
    chk("rst_ready", int'(change_ready), 1);
    chk("rst_q_cnt", int'(q_cnt), 0);

    // Three-coin payout in greedy order
    ack_mode = 2;
    refill(3, 4); refill(2, 4); refill(1, 4);
    start(40, lat);
    chk("t1_latency", lat, 2);
    chk("t1_first_coin", int'(coin_type), 3);
    expect_coin(2);
    expect_coin(1);
    wait_done(20, n);
    chk("t1_shortfall", int'(shortfall), 0);
    chk("t1_q", int'(q_cnt), 3);
    chk("t1_d", int'(d_cnt), 3);
    chk("t1_n", int'(n_cnt), 3);

    // Empty inventory
    do_reset();
    start(15, lat);
    chk("t2_latency", lat, 2);
    chk("t2_done", int'(done), 1);
    chk("t2_shortfall", int'(shortfall), 15);
    chk("t2_ready", int'(change_ready), 1);

    // Greedy leaves a shortfall; odd residue
    do_reset();
    refill(3, 1); refill(2, 3);
    start(30, lat);
    chk("t3_first_coin", int'(coin_type), 3);
    wait_done(20, n);
    chk("t3_shortfall", int'(shortfall), 5);
    chk("t3_d", int'(d_cnt), 3);
    chk("t3_q", int'(q_cnt), 0);
    refill(1, 2);
    start(7, lat);
    chk("t3_nickel", int'(coin_type), 1);
    wait_done(20, n);
    chk("t3_shortfall2", int'(shortfall), 2);
    chk("t3_n", int'(n_cnt), 1);

    // Saturating refill, refill+ack collision, ignored refill type
    do_reset();
    refill(1, 12);
    chk("t4_n12", int'(n_cnt), 12);
    refill(1, 10);
    chk("t4_sat", int'(n_cnt), 15);
    ack_mode = 3;
    start(5, lat);
    chk("t4_nickel", int'(coin_type), 1);
    man_ack = 1; refill_valid = 1; refill_type = 2'd1; refill_cnt = 4'd2;
    @(negedge clk);
    man_ack = 0; refill_valid = 0;
    chk("t4_collide", int'(n_cnt), 15);
    wait_done(20, n);
    chk("t4_shortfall", int'(shortfall), 0);
    refill(0, 5);
    chk("t4_type0_n", int'(n_cnt), 15);
    chk("t4_type0_d", int'(d_cnt), 0);
    chk("t4_type0_q", int'(q_cnt), 0);

    // Asynchronous reset mid-payout
    do_reset();
    ack_mode = 1;
    refill(3, 1);
    start(25, lat);
    chk("t5_coin_up", int'(coin_valid), 1);
    #2 rst = 0;
    #1;
    chk("t5_coin_valid", int'(coin_valid), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_q", int'(q_cnt), 0);
    @(negedge clk);
    rst = 1;
    ack_mode = 2;
    refill(2, 1);
    start(10, lat);
    chk("t5_latency", lat, 2);
    chk("t5_dime", int'(coin_type), 2);
    wait_done(20, n);
    chk("t5_shortfall", int'(shortfall), 0);

    // Ack never arrives
    do_reset();
    ack_mode = 1;
    refill(2, 1);
    start(10, lat);
`ifdef VM_CHANGE_TIMEOUT_EN
    wait_done(40, n);
    chk("t6_wait_cycles", n, 16);
    chk("t6_fault", int'(fault), 1);
    chk("t6_shortfall", int'(shortfall), 10);
    chk("t6_d", int'(d_cnt), 1);
    chk("t6_coin_valid", int'(coin_valid), 0);
`else
    repeat (100) @(negedge clk);
    chk("t6_still_valid", int'(coin_valid), 1);
    chk("t6_fault", int'(fault), 0);
    ack_mode = 2;
    wait_done(20, n);
    chk("t6_shortfall", int'(shortfall), 0);
    chk("t6_d", int'(d_cnt), 0);
`endif

    // Randomized traffic against the model
    do_reset();
    ack_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      change_valid = ($urandom_range(0, 3) == 0);
      change_amt   = AMT_W'($urandom_range(0, 80));
      refill_valid = ($urandom_range(0, 5) == 0);
      refill_type  = 2'($urandom_range(0, 3));
      refill_cnt   = INV_W'($urandom_range(0, 15));
    end
    change_valid = 0;
    refill_valid = 0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vm_change_dispenser.md
Name: vm_change_dispenser

Overview:
Downstream of the vending machine core (vm). Takes a change amount in cents from vm and pays it out one coin at a time to the coin-ejection mechanism, using a valid/ack handshake per coin. Tracks quarter, dime and nickel inventory, which the supplier refills. Reports completion and any amount it could not pay.

Parameters:
AMT_W, 8, width of change amount and shortfall in cents
INV_W, 4, width of each per-denomination coin counter (max 15)
INIT_CNT, 0, reset value of every inventory counter
TIMEOUT, 16, ack watchdog limit in cycles (used only with VM_CHANGE_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
change_valid  in  1  vm offers a change amount
change_amt  in  AMT_W  change owed, in cents
change_ready  out  1  block can accept a new amount
refill_valid  in  1  supplier refill strobe
refill_type  in  2  denomination to refill: 1 = nickel, 2 = dime, 3 = quarter, 0 = ignored
refill_cnt  in  INV_W  number of coins added
coin_valid  out  1  coin request to the mechanism
coin_type  out  2  coin requested, same encoding as refill_type
coin_ack  in  1  mechanism has ejected the coin
done  out  1  one-cycle pulse when payout ends
shortfall  out  AMT_W  unpaid cents; valid while done = 1, held until the next done
busy  out  1  not in IDLE
n_cnt, d_cnt, q_cnt  out  INV_W each  current coin inventory
fault  out  1  sticky watchdog flag (tied 0 unless VM_CHANGE_TIMEOUT_EN)

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE
  - coin_valid, coin_type, done, shortfall, fault = 0
  - n/d/q counters = INIT_CNT
  - internal remaining register = 0
- States: IDLE, SELECT, DISPENSE.
- IDLE:
  - change_ready = 1.
  - On change_valid && change_ready at a clock edge: remaining <= change_amt; go to SELECT.
  - change_amt = 0 is accepted and ends with done and shortfall = 0, with no coin issued.
- SELECT (one cycle). Greedy choice, evaluated in this order:
  - remaining >= 25 and q_cnt > 0: quarter
  - else remaining >= 10 and d_cnt > 0: dime
  - else remaining >= 5 and n_cnt > 0: nickel
  - If a coin is chosen: at the next edge coin_valid <= 1, coin_type is set, go to DISPENSE.
  - If none is chosen: at the next edge done <= 1 for one cycle, shortfall <= remaining, go to IDLE.
  - Amounts that are not a multiple of 5 leave the residue as shortfall.
  - Greedy is the required behaviour even when an exact combination exists.
- DISPENSE:
  - coin_valid and coin_type stay stable until coin_ack.
  - On the edge where coin_ack = 1: coin_valid <= 0, remaining minus the coin value, that counter decremented by 1, go to SELECT.
  - coin_ack is ignored in every other state.
- Latency:
  - First coin_valid is asserted two edges after acceptance.
  - Each further coin comes two edges after the previous ack.
  - An empty payout gives done two edges after acceptance.
- change_valid while busy is not accepted; vm must hold it until change_ready.
- Refill:
  - Accepted in any state: counter <= min(2^INV_W - 1, counter + refill_cnt), saturating.
  - Refill and ack on the same denomination in the same edge: counter <= min(max, counter - 1 + refill_cnt).
- Arithmetic: all cent arithmetic is unsigned AMT_W bits. remaining never underflows, because a coin is chosen only when remaining >= its value.
- Reset mid-payout: immediate abort to reset values. No done pulse; the unpaid amount is lost.

Optional Feature:
VM_CHANGE_TIMEOUT_EN:
- When defined:
  - A counter runs in DISPENSE and clears on entry.
  - If TIMEOUT cycles pass with no coin_ack: fault <= 1 (sticky until reset), coin_valid <= 0, done pulses, shortfall <= remaining (the requested coin is counted as unpaid and the inventory is not decremented), then go to IDLE.
- When undefined:
  - No counter logic.
  - fault is tied 0.
  - DISPENSE waits for coin_ack indefinitely.

Test Plan:
1. Refill with 4 quarters, 4 dimes, 4 nickels; change 40 -> coins quarter, dime, nickel in that order, each acked. Then done with shortfall 0; q/d/n counters = 3/3/3; first coin_valid two edges after acceptance.
2. Inventory empty (INIT_CNT = 0); change 15 -> no coin_valid. done pulses two edges after acceptance with shortfall 15; change_ready returns to 1.
3. Inventory q = 1, d = 3, n = 0; change 30 -> one quarter, then done with shortfall 5 (greedy), final d_cnt = 3. Change 7 with n = 2 -> one nickel, shortfall 2.
4. n_cnt = 12, refill nickel by 10 -> n_cnt = 15. With n_cnt = 15, a nickel ack and a refill of 2 nickels on the same edge -> n_cnt = 15. Refill with refill_type = 0 -> no counter change.
5. Drive rst low while coin_valid = 1 with remaining 25 -> coin_valid, done, busy = 0 with no clock edge needed; counters = INIT_CNT; after release, a new change_amt is accepted normally.
6. With VM_CHANGE_TIMEOUT_EN defined and TIMEOUT = 16; change 10 with d = 1 and coin_ack held 0 -> after 16 cycles in DISPENSE, fault = 1, done with shortfall 10, d_cnt still 1. Without the macro, coin_valid is still high after 100 cycles and fault = 0.
